// File: rtl/button_debounce_sync.sv
// button_debounce_sync: 2-flop synchroniser and per-bit debounce FSM producing level and press strobes
// Optional BTN_RELEASE_PULSE_EN adds btn_release, a one-cycle strobe on each accepted 1->0 transition.
module button_debounce_sync #(
  parameter int WIDTH = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             osc_clk,
  input  logic             reset_n,
  input  logic [WIDTH:0]   button,
  output logic [WIDTH:0]   btn_level,
  output logic [WIDTH:0]   btn_press,
`ifdef BTN_RELEASE_PULSE_EN
  output logic [WIDTH:0]   btn_release,
`endif
  output logic             any_press
);
  typedef enum logic [1:0] {STABLE_LO = 2'b00, CNT_HI = 2'b01, STABLE_HI = 2'b10, CNT_LO = 2'b11} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH:0] sync1, sync2, level_nxt, press_nxt;
  logic [CNT_W-1:0] cnt [WIDTH:0];
  logic [CNT_W-1:0] cnt_nxt [WIDTH:0];
  state_t st;
  logic differ, done;
`ifdef BTN_RELEASE_PULSE_EN
  logic [WIDTH:0] rel_nxt;
`endif
  // state is implied by the level and whether a count is in flight
  always_comb begin
    level_nxt = btn_level;
    press_nxt = '0;
`ifdef BTN_RELEASE_PULSE_EN
    rel_nxt = '0;
`endif
    st = STABLE_LO;
    differ = 1'b0;
    done = 1'b0;
    for (int b = 0; b <= WIDTH; b++) begin
      st = state_t'({btn_level[b], cnt[b] != '0});
      differ = sync2[b] != btn_level[b];
      done = differ && cnt[b] == LAST;
      cnt_nxt[b] = (!differ || done) ? '0 : cnt[b] + CNT_W'(1);
      level_nxt[b] = done ? sync2[b] : btn_level[b];
      press_nxt[b] = done && (st == STABLE_LO || st == CNT_HI);
`ifdef BTN_RELEASE_PULSE_EN
      rel_nxt[b] = done && (st == STABLE_HI || st == CNT_LO);
`endif
    end
  end
  always_ff @(posedge osc_clk) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      btn_level <= '0;
      btn_press <= '0;
      any_press <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
      btn_release <= '0;
`endif
      for (int b = 0; b <= WIDTH; b++) cnt[b] <= '0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      btn_level <= level_nxt;
      btn_press <= press_nxt;
      any_press <= |press_nxt;
`ifdef BTN_RELEASE_PULSE_EN
      btn_release <= rel_nxt;
`endif
      for (int b = 0; b <= WIDTH; b++) cnt[b] <= cnt_nxt[b];
    end
  end
endmodule

// File: tb/tb_button_debounce_sync.sv
// tb_button_debounce_sync: directed self-checking bench for button_debounce_sync (WIDTH=3, DEBOUNCE_CYCLES=4)
module tb_button_debounce_sync;
  logic osc_clk = 1'b0;
  logic reset_n;
  logic [3:0] button, btn_level, btn_press;
  logic any_press;
  int total = 0;
  int bad = 0;
`ifdef BTN_RELEASE_PULSE_EN
  logic [3:0] btn_release;
`endif
  button_debounce_sync #(.WIDTH(3), .DEBOUNCE_CYCLES(4)) dut (
    .osc_clk(osc_clk),
    .reset_n(reset_n),
    .button(button),
    .btn_level(btn_level),
    .btn_press(btn_press),
`ifdef BTN_RELEASE_PULSE_EN
    .btn_release(btn_release),
`endif
    .any_press(any_press)
  );
  always #5 osc_clk = ~osc_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge osc_clk);
    #1;
  endtask
  // edge e0 is the sync1 capture edge; the expected strobe lands on edge `at`
  task automatic run(input string tag, input int n, input int at, input logic [3:0] exp);
    for (int e = 0; e < n; e++) begin
      tick();
      check($sformatf("%s e%0d", tag, e), {27'b0, any_press, btn_press}, (e == at) ? {27'b0, |exp, exp} : 32'b0);
    end
  endtask
  initial begin
    reset_n = 1'b0;
    button = 4'hF;
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("rst_out%0d", k), {23'b0, btn_level, btn_press, any_press}, 32'b0);
`ifdef BTN_RELEASE_PULSE_EN
      check($sformatf("rst_rel%0d", k), {28'b0, btn_release}, 32'b0);
`endif
    end
    reset_n = 1'b1;
    run("rst_idle", 7, 5, 4'hF);
    check("rst_idle_lvl", {28'b0, btn_level}, 32'hF);
    button = 4'h0;
    run("all_low", 7, -1, 4'h0);
    check("all_low_lvl", {28'b0, btn_level}, 32'h0);
    button = 4'h9;
    run("press9", 20, 5, 4'h9);
    check("press9_lvl", {28'b0, btn_level}, 32'h9);
    for (int k = 0; k < 4; k++) begin
      button = (k % 2 == 0) ? 4'hB : 4'h9;
      run("bounce", 2, -1, 4'h0);
    end
    button = 4'h9;
    run("bounce_idle", 8, -1, 4'h0);
    check("bounce_lvl", {28'b0, btn_level}, 32'h9);
    button = 4'hD;
    run("glitch_hi", 3, -1, 4'h0);
    button = 4'h9;
    run("glitch_lo", 1, -1, 4'h0);
    button = 4'hD;
    run("settle", 10, 5, 4'h4);
    check("settle_lvl", {28'b0, btn_level}, 32'hD);
    button = 4'h0;
    run("clear", 7, -1, 4'h0);
    check("clear_lvl", {28'b0, btn_level}, 32'h0);
    button = 4'h8;
    run("pre_rst", 4, -1, 4'h0);
    reset_n = 1'b0;
    tick();
    check("mid_rst_out", {23'b0, btn_level, btn_press, any_press}, 32'b0);
    reset_n = 1'b1;
    run("mid_rst", 8, 5, 4'h8);
    check("mid_rst_lvl", {28'b0, btn_level}, 32'h8);
    button = 4'h0;
    run("clear2", 7, -1, 4'h0);
    check("clear2_lvl", {28'b0, btn_level}, 32'h0);
`ifdef BTN_RELEASE_PULSE_EN
    button = 4'h4;
    run("rel_press", 10, 5, 4'h4);
    button = 4'h0;
    for (int e = 0; e < 8; e++) begin
      tick();
      check($sformatf("rel e%0d", e), {23'b0, any_press, btn_press, btn_release}, (e == 5) ? 32'h4 : 32'h0);
    end
    check("rel_lvl", {28'b0, btn_level}, 32'h0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/button_debounce_sync.md
Name: button_debounce_sync

Overview:
- Input-conditioning stage that sits directly upstream of the LED/button game core.
- Takes the raw, asynchronous, bouncing push-button vector.
- Produces a synchronised, debounced level vector and single-cycle press strobes.
- The game core consumes these strobes in place of raw buttons, so one physical press is one game event.

Parameters:
- WIDTH, 3, MSB index of the button vector; WIDTH+1 buttons are handled.
- DEBOUNCE_CYCLES, 4, consecutive osc_clk cycles a new synchronised level must hold before it is accepted; legal range 1..65535.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of each per-button stability counter; derived, not to be overridden.

Ports:
- osc_clk  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- button  input  WIDTH+1  raw asynchronous buttons, active-high.
- btn_level  output  WIDTH+1  debounced, synchronised button level.
- btn_press  output  WIDTH+1  one-cycle strobe per bit on each accepted 0->1 transition.
- any_press  output  1  OR of btn_press, registered in the same cycle as btn_press.
- btn_release  output  WIDTH+1  present only with BTN_RELEASE_PULSE_EN; see Optional Feature.

Behaviour:
- Interface rule: one clock, osc_clk; reset_n is synchronous and active-low, sampled only on the osc_clk rising edge.
- Reset (reset_n=0 at an edge) clears, for every bit:
  - sync1, sync2, btn_level, counter, btn_press, any_press and btn_release all go to 0.
  - Reset takes priority over every other event.
- Synchroniser: per bit, a 2-flop chain button -> sync1 -> sync2. Only sync2 is used downstream.
- Per-bit FSM:
  - States: STABLE_LO, CNT_HI, STABLE_HI, CNT_LO.
  - State is encoded by btn_level together with counter!=0.
- At each edge, per bit:
  - If sync2==btn_level: counter<=0 and the bit stays in, or returns to, its STABLE state. This is how a bounce aborts a pending count.
  - If sync2!=btn_level and counter<DEBOUNCE_CYCLES-1: counter<=counter+1 (CNT_HI or CNT_LO).
  - If sync2!=btn_level and counter==DEBOUNCE_CYCLES-1: btn_level<=sync2 and counter<=0.
    - On that same edge, if the new level is 1, btn_press<=1 for exactly one cycle.
- Strobe rules:
  - btn_press is 0 on every edge where no 0->1 acceptance occurs.
  - any_press <= OR of the next-state btn_press bits. It is asserted in the same cycle as btn_press.
- Latency: let edge 0 be the first edge at which sync1 captures a new stable level. btn_level/btn_press update at edge DEBOUNCE_CYCLES+1.
  - Example: DEBOUNCE_CYCLES=4 gives edge 5.
  - DEBOUNCE_CYCLES=1 gives edge 2, i.e. synchroniser delay only.
- Filtering: any input pulse or gap whose synchronised width is shorter than DEBOUNCE_CYCLES cycles produces no change on any output.
- Independence: bits are fully independent. Simultaneous acceptances on several bits raise several btn_press bits in the same cycle, with any_press=1 once.
- Counter: never wraps. The maximum value reached is DEBOUNCE_CYCLES-1.
- Held button: produces exactly one btn_press, with no auto-repeat.
- Reset mid-count: the pending transition is discarded.
  - If the button is still high when reset_n returns to 1, the sequence restarts from sync1 capture.
  - btn_press then appears DEBOUNCE_CYCLES+2 edges after the first edge with reset_n=1.

Optional Feature:
- Macro BTN_RELEASE_PULSE_EN.
- Defined:
  - Adds the btn_release output, WIDTH+1 bits, reset value 0.
  - A bit pulses 1 for exactly one cycle on the edge where btn_level is accepted 1->0, with the same latency rules as btn_press.
  - any_press is unaffected by releases.
- Undefined:
  - The btn_release port and its registers do not exist.
  - The 1->0 acceptance still updates btn_level but generates no strobe.

Test Plan (WIDTH=3, DEBOUNCE_CYCLES=4, 10 ns clock):
1. Reset then idle:
   - Stimulus: reset_n=0 for 2 edges with button=4'b1111.
   - Required: every output is 0 while reset_n=0.
   - Then, after release: btn_level=4'b1111 and btn_press=4'b1111 for one cycle at edge 6 after reset_n=1 (counting the first edge with reset_n=1 as edge 1); any_press=1 in that cycle only.
2. Clean press:
   - Stimulus: button 4'b0000 -> 4'b1001, held 20 cycles.
   - Required: btn_press=4'b1001 for exactly one cycle, 5 edges after the sync1 capture; btn_level=4'b1001 thereafter; no further strobes.
3. Bounce rejection:
   - Stimulus: button[1] toggles 1,0,1,0 with 2-cycle widths, then settles at 0.
   - Required: btn_level[1] and btn_press[1] stay 0 throughout.
4. Bounce then settle:
   - Stimulus: button[2] gives a 3-cycle high glitch, 1 low, then stays high.
   - Required: exactly one btn_press[2] pulse, 5 edges after the final settling capture.
5. Reset mid-count:
   - Stimulus: button=4'b1000 applied; reset_n=0 for one edge while counter=2.
   - Required: outputs clear; btn_press[3] appears only at edge 6 after reset_n=1 (first edge with reset_n=1 = edge 1), once.
6. With BTN_RELEASE_PULSE_EN:
   - Stimulus: press and hold 4'b0100 for 10 cycles, then release.
   - Required: one btn_press[2] pulse; then one btn_release[2] pulse 5 edges after the release capture; any_press stays 0 on release.
